// File: rtl/sico_if_arbiter_pkg.sv
// Shared constants and helpers for the SiCo stream arbiter and its round-robin picker.
package sico_if_arbiter_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // $clog2 that never returns less than one bit
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sico_rr_pick.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ... modulo N.
module sico_rr_pick
    import sico_if_arbiter_pkg::*;
#(
    parameter int unsigned N    = 2,
    parameter int unsigned ID_W = 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic            any_c,
    output logic [ID_W-1:0] idx_c
);

    logic [31:0] cand;

    always_comb begin
        any_c = 1'b0;
        idx_c = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!any_c && req_i[cand[ID_W-1:0]]) begin
                any_c = 1'b1;
                idx_c = cand[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sico_if_arbiter.sv
// Round-robin arbiter sharing one SiCo valid/hold stream between N requesters,
// with bounded bursts and a source tag on the downstream side.
module sico_if_arbiter
    import sico_if_arbiter_pkg::*;
#(
    parameter  int unsigned N     = 2,
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned BURST = 4,
    localparam int unsigned ID_W  = clog2_min1(N)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N-1:0]         req_valid_i,
    input  logic [N*WIDTH-1:0]   req_data_i,
    output logic [N-1:0]         req_hold_o,
    output logic                 valid_o,
    output logic [WIDTH-1:0]     data_o,
    output logic [ID_W-1:0]      src_o,
    input  logic                 hold_i,
    output logic                 busy_o
);

    localparam int unsigned CNT_W    = clog2_min1(BURST + 1);
    localparam int unsigned LAST_CNT = (BURST == 0) ? 0 : BURST - 1;

    logic [0:0]       state_q, state_d;
    logic [ID_W-1:0]  g_q, g_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             pick_any;
    logic [ID_W-1:0]  pick_idx;
    logic             grant_c;
    logic             g_valid_c;
    logic             xfer_c;
    logic [WIDTH-1:0] data_arr [N];

    sico_rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .any_c (pick_any),
        .idx_c (pick_idx)
    );

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign data_arr[i]   = req_data_i[i*WIDTH +: WIDTH];
        // only the granted lane sees downstream back-pressure; everyone else waits
        assign req_hold_o[i] = ~(grant_c && (g_q == ID_W'(i))) | hold_i;
    end

    assign grant_c   = (state_q == ST_GRANT);
    assign g_valid_c = req_valid_i[g_q];
    assign xfer_c    = grant_c && g_valid_c && !hold_i;

    // Downstream side is a pass-through of the granted lane
    always_comb begin
        valid_o = grant_c && g_valid_c;
        data_o  = grant_c ? data_arr[g_q] : '0;
        src_o   = g_q;
        busy_o  = grant_c;
    end

    // Next-state: grant on any request, release on burst end or requester withdrawal
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (pick_any) begin
                state_d = ST_GRANT;
                g_d     = pick_idx;
                cnt_d   = '0;
            end
        end else begin
            if (!g_valid_c || (xfer_c && (BURST != 0) && (cnt_q == CNT_W'(LAST_CNT)))) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                ptr_d   = (g_q == ID_W'(N - 1)) ? '0 : g_q + ID_W'(1);
            end else if (xfer_c) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
